aer_core_event_dispatcher: RTL

- Input-side counterpart of the multi-core output arbiter.
- Accepts one AER event stream from the previous layer over a 4-phase req/ack link and distributes each event to the CORE_NUM cores of the layer, each with its own 4-phase req/ack link.
- Neuron spikes and timestep markers are broadcast to all cores; config/unicast events go to one core.
- Upstream ack completes only after every targeted core has completed its handshake, so all cores advance timesteps in lockstep.

---
 rtl/aer_pkg.sv | 25 ++
 rtl/aer_hs_collector.sv | 53 +++++
 rtl/aer_core_event_dispatcher.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aer_pkg.sv
// Shared AER event encoding and dispatcher FSM states.
// The output arbiter decodes the event type field with the same helper.
package aer_pkg;

    typedef logic [1:0] evt_t;

    localparam evt_t EVT_NEURON   = 2'b00;
    localparam evt_t EVT_TIMESTEP = 2'b01;
    localparam evt_t EVT_UNICAST  = 2'b10;
    localparam evt_t EVT_RSVD     = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISPATCH = 2'b01,
        RELEASE  = 2'b10,
        UP_ACK   = 2'b11
    } state_t;

    // Type field is the top two bits of an event of the given width.
    function automatic evt_t evt_type(input logic [31:0] addr,
                                      input int unsigned width);
        return addr[width-1 -: 2];
    endfunction

endpackage

// File: rtl/aer_hs_collector.sv
// Tracks target/done masks over N parallel 4-phase req/ack links and
// reports when every targeted link has acked and then released its ack.
module aer_hs_collector #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_target,
    input  logic         i_sample,
    input  logic         i_force,
    input  logic         i_clear,
    input  logic [N-1:0] i_ack,
    output logic [N-1:0] o_req_nxt,
    output logic         o_all_done,
    output logic         o_all_released
);

    logic [N-1:0] r_target;
    logic [N-1:0] r_done;
    logic [N-1:0] w_done_nxt;

    always_comb begin
        w_done_nxt = r_done;
        if (i_sample) begin
            w_done_nxt = r_done | (i_ack & r_target);
        end
        if (i_force) begin
            w_done_nxt = r_done | r_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target <= '0;
            r_done   <= '0;
        end else if (i_clear) begin
            r_target <= '0;
            r_done   <= '0;
        end else if (i_load) begin
            r_target <= i_target;
            r_done   <= '0;
        end else begin
            r_done   <= w_done_nxt;
        end
    end

    // Requests drop on the same edge that records the ack.
    assign o_req_nxt      = r_target & ~w_done_nxt;
    assign o_all_done     = (r_done & r_target) == r_target;
    assign o_all_released = (i_ack & r_target) == '0;

endmodule

// File: rtl/aer_core_event_dispatcher.sv
// Fans one upstream AER event out to CORE_NUM cores over 4-phase links.
// Optional per-event core-ack timeout: define AER_DISPATCH_TIMEOUT_EN.
module aer_core_event_dispatcher #(
    parameter int CORE_NUM     = 16,
    parameter int AER_IN_WIDTH = 12,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_req,
    input  logic [AER_IN_WIDTH-1:0] in_addr,
    output logic                    in_ack,
    output logic [CORE_NUM-1:0]     core_req,
    output logic [AER_IN_WIDTH-1:0] core_addr,
    input  logic [CORE_NUM-1:0]     core_ack,
    output logic                    busy,
    output logic [15:0]             tstep_cnt,
    output logic                    err_flag
);

    import aer_pkg::*;

    localparam int CORE_ID_W = $clog2(CORE_NUM);

    state_t                  r_state;
    state_t                  w_next;
    logic [CORE_NUM-1:0]     r_core_req;
    logic [AER_IN_WIDTH-1:0] r_core_addr;
    logic                    r_in_ack;
    logic [15:0]             r_tstep_cnt;
    logic [CORE_NUM-1:0]     w_target;
    logic [CORE_NUM-1:0]     w_req_nxt;
    logic                    w_load;
    logic                    w_clear;
    logic                    w_all_done;
    logic                    w_all_released;
    logic                    w_timeout;
    evt_t                    w_type_in;
    evt_t                    w_type_cur;

    assign w_type_in  = evt_type(32'(in_addr), AER_IN_WIDTH);
    assign w_type_cur = evt_type(32'(r_core_addr), AER_IN_WIDTH);

    always_comb begin
        w_target = '0;
        unique case (w_type_in)
            EVT_NEURON, EVT_TIMESTEP: w_target = '1;
            EVT_UNICAST: w_target[in_addr[CORE_ID_W-1:0]] = 1'b1;
            default: w_target = '0;
        endcase
    end

    aer_hs_collector #(
        .N(CORE_NUM)
    ) u_coll (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_load),
        .i_target       (w_target),
        .i_sample       (r_state == DISPATCH),
        .i_force        (w_timeout),
        .i_clear        (w_clear),
        .i_ack          (core_ack),
        .o_req_nxt      (w_req_nxt),
        .o_all_done     (w_all_done),
        .o_all_released (w_all_released)
    );

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_clear = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_req) begin
                    w_load = 1'b1;
                    w_next = (w_type_in == EVT_RSVD) ? UP_ACK : DISPATCH;
                end
            end
            DISPATCH: begin
                if (w_timeout)       w_next = UP_ACK;
                else if (w_all_done) w_next = RELEASE;
            end
            RELEASE: begin
                if (w_timeout || w_all_released) w_next = UP_ACK;
            end
            UP_ACK: begin
                if (!in_req) begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end
            end
            default: begin
                w_next  = IDLE;
                w_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_core_req  <= '0;
            r_core_addr <= '0;
            r_in_ack    <= 1'b0;
            r_tstep_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_core_req <= (r_state == DISPATCH) ? w_req_nxt : '0;
            r_in_ack   <= (r_state == UP_ACK) && (w_next == UP_ACK);
            if (w_load) begin
                r_core_addr <= in_addr;
            end
            if (r_state == UP_ACK && !in_req && w_type_cur == EVT_TIMESTEP) begin
                r_tstep_cnt <= r_tstep_cnt + 16'd1;
            end
        end
    end

`ifdef AER_DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_waiting;

    assign w_waiting = (r_state == DISPATCH) || (r_state == RELEASE);
    assign w_timeout = w_waiting && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= w_waiting ? r_to_cnt + 1'b1 : '0;
            r_err    <= r_err | w_timeout;
        end
    end

    assign err_flag = r_err;
`else
    logic w_unused_to;

    assign w_unused_to = (TIMEOUT_CYC > 0);
    assign w_timeout   = 1'b0;
    assign err_flag    = 1'b0;
`endif

    assign in_ack    = r_in_ack;
    assign core_req  = r_core_req;
    assign core_addr = r_core_addr;
    assign busy      = (r_state != IDLE);
    assign tstep_cnt = r_tstep_cnt;

endmodule
